// File: rtl/mash_nstage.sv
// MASH delta-sigma modulator: 1..STAGES cascaded first-order accumulators, noise-cancellation network, saturating output.
// Optional MASH_DITHER_EN adds a 16-bit LFSR LSB dither on the first stage input.
module mash_nstage #(
  parameter int STAGES = 4,
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [2:0]              order,
  input  logic [OUT_W+FRAC_W-1:0] tgt_in,
  output logic [OUT_W-1:0]        val_out,
  output logic                    out_valid,
  output logic                    sat,
  output logic [FRAC_W-1:0]       acc_out
);

  localparam logic [2:0] MAX_N = 3'(STAGES);
  localparam logic signed [OUT_W+4:0] MAX_V = {5'b0, {OUT_W{1'b1}}};

  logic [FRAC_W-1:0] acc_q [4];
  logic [FRAC_W-1:0] acc_d [4];
  // hist: [0]=c2 z^-1, [1]=c3 z^-1, [2]=c3 z^-2, [3]=c4 z^-1, [4]=c4 z^-2, [5]=c4 z^-3
  logic [5:0]        hist_q, hist_d, hist_m;
  logic [3:0]        carry, act;
  logic [2:0]        n_act;
  logic [OUT_W-1:0]  int_part, val_q, val_d;
  logic [FRAC_W-1:0] frac, accout_q, accout_d;
  logic              sat_q, sat_d, valid_q;
  logic [FRAC_W:0]   x, s;
  logic signed [4:0] y;
  logic signed [OUT_W+4:0] sum;
  logic [OUT_W:0]    clamped;
  logic              dither;

`ifdef MASH_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign dither = lfsr_q[0];
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`else
  assign dither = 1'b0;
`endif

  // Weighted contribution of one carry/history bit.
  function automatic logic signed [4:0] wbit(input logic b, input logic signed [4:0] w);
    return b ? w : 5'sd0;
  endfunction

  // y = c1 + D(c2) + D^2(c3) + D^3(c4), inactive stages already masked to zero.
  function automatic logic signed [4:0] noise_cancel(input logic [3:0] c, input logic [5:0] h);
    logic signed [4:0] acc;
    acc = wbit(c[0], 5'sd1);
    acc = acc + wbit(c[1], 5'sd1) - wbit(h[0], 5'sd1);
    acc = acc + wbit(c[2], 5'sd1) - wbit(h[1], 5'sd2) + wbit(h[2], 5'sd1);
    acc = acc + wbit(c[3], 5'sd1) - wbit(h[3], 5'sd3) + wbit(h[4], 5'sd3) - wbit(h[5], 5'sd1);
    return acc;
  endfunction

  // Saturate to [0, 2^OUT_W-1]; MSB of result flags clamping.
  function automatic logic [OUT_W:0] clamp_out(input logic signed [OUT_W+4:0] v);
    if (v[OUT_W+4])
      return {1'b1, {OUT_W{1'b0}}};
    else if (v > MAX_V)
      return {1'b1, {OUT_W{1'b1}}};
    else
      return {1'b0, v[OUT_W-1:0]};
  endfunction

  always_comb begin
    int_part = tgt_in[OUT_W+FRAC_W-1:FRAC_W];
    frac     = tgt_in[FRAC_W-1:0];
    n_act    = (order > MAX_N) ? MAX_N : order;
    x        = {1'b0, frac} + {{FRAC_W{1'b0}}, dither};
    s        = '0;
    for (int k = 0; k < 4; k++) begin
      act[k] = (k < STAGES) && (3'(k) < n_act);
      s      = {1'b0, acc_q[k]} + x;
      if (act[k]) begin
        acc_d[k] = s[FRAC_W-1:0];
        carry[k] = s[FRAC_W];
      end else begin
        acc_d[k] = '0;
        carry[k] = 1'b0;
      end
      x = {1'b0, acc_d[k]};
    end

    hist_m = hist_q & {act[3], act[3], act[3], act[2], act[2], act[1]};
    hist_d = {hist_m[4], hist_m[3], carry[3], hist_m[1], carry[2], carry[1]};

    y       = noise_cancel(carry, hist_m);
    sum     = $signed({5'b0, int_part}) + {{OUT_W{y[4]}}, y};
    clamped = clamp_out(sum);
    val_d   = clamped[OUT_W-1:0];
    sat_d   = clamped[OUT_W];

    accout_d = frac;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) + 3'd1 == n_act) accout_d = acc_d[k];
    end
  end

  // ---- output / state register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) acc_q[k] <= '0;
      hist_q   <= '0;
      val_q    <= '0;
      sat_q    <= 1'b0;
      accout_q <= '0;
      valid_q  <= 1'b0;
`ifdef MASH_DITHER_EN
      lfsr_q   <= 16'hACE1;
`endif
    end else begin
      valid_q <= tick;
      if (tick) begin
        for (int k = 0; k < 4; k++) acc_q[k] <= acc_d[k];
        hist_q   <= hist_d;
        val_q    <= val_d;
        sat_q    <= sat_d;
        accout_q <= accout_d;
`ifdef MASH_DITHER_EN
        lfsr_q   <= lfsr_d;
`endif
      end
    end
  end

  assign val_out   = val_q;
  assign out_valid = valid_q;
  assign sat       = sat_q;
  assign acc_out   = accout_q;

endmodule
